mandel_pixel_scheduler: RTL

- Sequences one Mandelbrot frame: walks pixel coordinates in raster order and dispatches each pixel round-robin to N_CORES iteration engines.
- Collects results strictly in issue order and emits them as an AXI-Stream pixel stream (tuser = SOF, tlast = EOL).
- Feeds the downstream colour-map/word packer inside the pixel generator.

---
 rtl/mandel_pkg.sv | 26 ++
 rtl/mandel_pixel_scheduler_raster.sv | 57 +++++
 rtl/mandel_pixel_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mandel_pkg.sv
// Shared types and helpers for the Mandelbrot pixel scheduler.
package mandel_pkg;

    localparam int N_CORES_DEF = 4;
    localparam int X_W_DEF     = 10;
    localparam int Y_W_DEF     = 9;
    localparam int ITER_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sched_state_t;

    typedef logic [ITER_W_DEF-1:0] iter_t;
    typedef logic [X_W_DEF-1:0]    coord_x_t;
    typedef logic [Y_W_DEF-1:0]    coord_y_t;

    // Index width for a core pointer; a single core still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CORE_IDX_W = idx_w(N_CORES_DEF);

endpackage

// File: rtl/mandel_pixel_scheduler_raster.sv
// Raster-order x/y counter with end-of-line and end-of-frame flags.
module raster_counter
    import mandel_pkg::*;
#(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clr_i,
    input  logic           adv_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           at_eol_o,
    output logic           at_eof_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    assign at_eol_o = (x_q == X_LAST);
    assign at_eof_o = at_eol_o && (y_q == Y_LAST);
    assign x_o      = x_q;
    assign y_o      = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (at_eol_o) begin
                x_d = '0;
                y_d = at_eof_o ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Frame sequencer: round-robin pixel issue to N_CORES engines, in-order AXI-Stream collect.
// Optional MANDEL_SCHED_PERF_EN adds frame_cycles / stall_cycles counters.
module mandel_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int ITER_W  = 8
) (
    input  logic                      out_stream_aclk,
    input  logic                      periph_resetn,
    input  logic                      start,
    output logic                      busy,
    output logic                      frame_done,
    output logic [N_CORES-1:0]        core_start,
    output logic [X_W-1:0]            core_x,
    output logic [Y_W-1:0]            core_y,
    input  logic [N_CORES-1:0]        core_ready,
    input  logic [N_CORES-1:0]        core_done,
    input  logic [N_CORES*ITER_W-1:0] core_iter,
    output logic [N_CORES-1:0]        core_ack,
    output logic [ITER_W-1:0]         m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tuser,
    output logic                      m_tlast
`ifdef MANDEL_SCHED_PERF_EN
    ,
    output logic [31:0]               frame_cycles,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int IDX_W = idx_w(N_CORES);
    localparam int IF_W  = $clog2(N_CORES + 1);

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  iss_ptr_q, iss_ptr_d, col_ptr_q, col_ptr_d;
    logic [IF_W-1:0]   in_flight_q, in_flight_d;
    logic [ITER_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic [N_CORES-1:0] pend_q;

    logic start_acc, issue, load, hs;
    logic iss_eol, iss_eof, out_eol, out_eof;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(N_CORES - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .X_W(X_W), .Y_W(Y_W)) u_iss (
        .clk_i    (out_stream_aclk),
        .rst_ni   (periph_resetn),
        .clr_i    (start_acc),
        .adv_i    (issue),
        .x_o      (core_x),
        .y_o      (core_y),
        .at_eol_o (iss_eol),
        .at_eof_o (iss_eof)
    );

    // Output-side counter tracks handshaken beats, so tuser/tlast follow the stream.
    raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .X_W(X_W), .Y_W(Y_W)) u_out (
        .clk_i    (out_stream_aclk),
        .rst_ni   (periph_resetn),
        .clr_i    (start_acc),
        .adv_i    (hs),
        .x_o      (out_x),
        .y_o      (out_y),
        .at_eol_o (out_eol),
        .at_eof_o (out_eof)
    );

    always_comb begin
        state_d    = state_q;
        start_acc  = 1'b0;
        issue      = 1'b0;
        frame_done = 1'b0;
        hs         = tvalid_q && m_tready;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                issue = core_ready[iss_ptr_q] && (in_flight_q < IF_W'(N_CORES));
                if (issue && iss_eol && iss_eof) state_d = DRAIN;
            end
            DRAIN: begin
                if (hs && out_eof) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        load = (state_q != IDLE) && core_done[col_ptr_q] && (!tvalid_q || m_tready);

        core_start = '0;
        if (issue) core_start[iss_ptr_q] = 1'b1;
        core_ack = '0;
        if (load) core_ack[col_ptr_q] = 1'b1;

        iss_ptr_d = start_acc ? '0 : (issue ? next_idx(iss_ptr_q) : iss_ptr_q);
        col_ptr_d = start_acc ? '0 : (load  ? next_idx(col_ptr_q) : col_ptr_q);

        in_flight_d = in_flight_q;
        unique case ({issue, load})
            2'b10:   in_flight_d = in_flight_q + IF_W'(1);
            2'b01:   in_flight_d = in_flight_q - IF_W'(1);
            default: in_flight_d = in_flight_q;
        endcase

        tdata_d  = load ? core_iter[col_ptr_q*ITER_W +: ITER_W] : tdata_q;
        tvalid_d = load ? 1'b1 : (hs ? 1'b0 : tvalid_q);
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            state_q     <= IDLE;
            iss_ptr_q   <= '0;
            col_ptr_q   <= '0;
            in_flight_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            iss_ptr_q   <= iss_ptr_d;
            col_ptr_q   <= col_ptr_d;
            in_flight_q <= in_flight_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            pend_q      <= (pend_q & ~core_ack) | core_start;
        end
    end

    assign busy     = (state_q != IDLE) && !frame_done;
    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tuser  = tvalid_q && (out_x == '0) && (out_y == '0);
    assign m_tlast  = tvalid_q && out_eol;

    // A core may only report a result for a job it was actually given.
    a_done_has_job: assert property (@(posedge out_stream_aclk) disable iff (!periph_resetn)
        (core_done & ~pend_q) == '0)
        else $error("core_done on a core with no outstanding job");

`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] cyc_q, stall_q, frame_cycles_q, stall_cycles_q;

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            cyc_q          <= '0;
            stall_q        <= '0;
            frame_cycles_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (start_acc) begin
                cyc_q   <= '0;
                stall_q <= '0;
            end else if (state_q != IDLE) begin
                cyc_q <= cyc_q + 32'd1;
                if (state_q == RUN && !issue) stall_q <= stall_q + 32'd1;
            end
            if (frame_done) begin
                frame_cycles_q <= cyc_q + 32'd1;
                stall_cycles_q <= stall_q;
            end
        end
    end

    assign frame_cycles = frame_cycles_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule
